// File: rtl/bist_sequencer.sv
// BIST sequencer: on a START rising edge runs SEED -> (SHIFT, CAPTURE) x N_PATTERNS -> UNLOAD -> DONE.
// All outputs are registered decodes of the next state, so they line up with the state register.
module bist_sequencer #(
  parameter int CHAIN_LEN   = 5,
  parameter int N_PATTERNS  = 100,
  parameter int SEED_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             scan_en,
  output logic             seed,
  output logic             capture,
  output logic             running,
  output logic             finish,
  output logic             bist_end,
  output logic [CNT_W-1:0] pattern_cnt
);

  localparam int PH_MAX = (CHAIN_LEN > SEED_CYCLES) ? CHAIN_LEN : SEED_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0]  SEED_LOAD  = PH_W'(SEED_CYCLES - 1);
  localparam logic [PH_W-1:0]  CHAIN_LOAD = PH_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] N_PAT      = CNT_W'(N_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_SHIFT, S_CAPTURE, S_UNLOAD, S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PH_W-1:0]  phase_cnt;
  logic [PH_W-1:0]  phase_next;
  logic [CNT_W-1:0] cnt_next;
  logic             start_q;
  logic             armed;
  logic             start_edge;

  // armed stays low after reset until START is seen low, so a START held
  // across reset release is not mistaken for a fresh request.
  assign start_edge = start & ~start_q & armed;

  always_comb begin
    state_next = state;
    phase_next = phase_cnt;
    cnt_next   = pattern_cnt;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          state_next = S_SEED;
          phase_next = SEED_LOAD;
          cnt_next   = '0;
        end
      end
      S_SEED: begin
        if (phase_cnt == '0) begin
          state_next = S_SHIFT;
          phase_next = CHAIN_LOAD;
        end else begin
          phase_next = phase_cnt - PH_W'(1);
        end
      end
      S_SHIFT: begin
        if (phase_cnt == '0) begin
          state_next = S_CAPTURE;
          phase_next = '0;
        end else begin
          phase_next = phase_cnt - PH_W'(1);
        end
      end
      S_CAPTURE: begin
        if (pattern_cnt != N_PAT) begin
          cnt_next = pattern_cnt + CNT_W'(1);
        end
        state_next = (cnt_next == N_PAT) ? S_UNLOAD : S_SHIFT;
        phase_next = CHAIN_LOAD;
      end
      S_UNLOAD: begin
        if (phase_cnt == '0) begin
          state_next = S_DONE;
          phase_next = '0;
        end else begin
          phase_next = phase_cnt - PH_W'(1);
        end
      end
      S_DONE: begin
        if (!start) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        phase_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      pattern_cnt <= '0;
      start_q     <= 1'b0;
      armed       <= 1'b0;
      seed        <= 1'b0;
      scan_en     <= 1'b0;
      capture     <= 1'b0;
      running     <= 1'b0;
      finish      <= 1'b0;
      bist_end    <= 1'b0;
    end else begin
      state       <= state_next;
      phase_cnt   <= phase_next;
      pattern_cnt <= cnt_next;
      start_q     <= start;
      armed       <= armed | ~start;
      seed        <= (state_next == S_SEED);
      scan_en     <= (state_next == S_SHIFT) || (state_next == S_UNLOAD);
      capture     <= (state_next == S_CAPTURE);
      running     <= (state_next != S_IDLE) && (state_next != S_DONE);
      finish      <= (state_next == S_DONE) && (state != S_DONE);
      bist_end    <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: two instances (4/3/2 and 1/1/1) checked cycle by cycle
// against a closed-form phase schedule, plus continuous exclusivity checks.
module tb_bist_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic scan_en_a, seed_a, capture_a, running_a, finish_a, bist_end_a;
  logic scan_en_b, seed_b, capture_b, running_b, finish_b, bist_end_b;
  logic [7:0] cnt_a, cnt_b;

  int compared   = 0;
  int mismatched = 0;
  bit chk_on     = 1'b0;

  always #5 clk = ~clk;

  bist_sequencer #(.CHAIN_LEN(4), .N_PATTERNS(3), .SEED_CYCLES(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .scan_en(scan_en_a), .seed(seed_a), .capture(capture_a), .running(running_a),
    .finish(finish_a), .bist_end(bist_end_a), .pattern_cnt(cnt_a)
  );

  bist_sequencer #(.CHAIN_LEN(1), .N_PATTERNS(1), .SEED_CYCLES(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .scan_en(scan_en_b), .seed(seed_b), .capture(capture_b), .running(running_b),
    .finish(finish_b), .bist_end(bist_end_b), .pattern_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_idle(input string tag, input int exp_cnt, input bit exp_end);
    chk({tag, "_seed"}, 32'(seed_a), 0);
    chk({tag, "_scan"}, 32'(scan_en_a), 0);
    chk({tag, "_cap"}, 32'(capture_a), 0);
    chk({tag, "_run"}, 32'(running_a), 0);
    chk({tag, "_fin"}, 32'(finish_a), 0);
    chk({tag, "_end"}, 32'(bist_end_a), 32'(exp_end));
    chk({tag, "_cnt"}, 32'(cnt_a), 32'(exp_cnt));
  endtask

  // Walks one run from the first SEED cycle (t=0) to the first DONE cycle.
  task automatic run_check(input bit use_b, input int cl, input int n, input int sc,
                           input int toggle_at);
    int total;
    int scan_cnt, cap_cnt, fin_cnt;
    total = sc + n * (cl + 1) + cl;
    scan_cnt = 0; cap_cnt = 0; fin_cnt = 0;
    for (int t = 0; t <= total; t++) begin
      bit e_seed, e_scan, e_cap, e_run, e_fin, e_end;
      int e_cnt, u;
      logic o_seed, o_scan, o_cap, o_run, o_fin, o_end;
      logic [7:0] o_cnt;
      step();
      e_seed = 0; e_scan = 0; e_cap = 0; e_run = 0; e_fin = 0; e_end = 0; e_cnt = 0;
      if (t < sc) begin
        e_seed = 1; e_run = 1;
      end else begin
        u = t - sc;
        if (u < n * (cl + 1)) begin
          e_run = 1;
          e_cnt = u / (cl + 1);
          if ((u % (cl + 1)) < cl) e_scan = 1; else e_cap = 1;
        end else if (u < n * (cl + 1) + cl) begin
          e_run = 1; e_scan = 1; e_cnt = n;
        end else begin
          e_end = 1; e_fin = 1; e_cnt = n;
        end
      end
      if (use_b) begin
        o_seed = seed_b; o_scan = scan_en_b; o_cap = capture_b; o_run = running_b;
        o_fin = finish_b; o_end = bist_end_b; o_cnt = cnt_b;
      end else begin
        o_seed = seed_a; o_scan = scan_en_a; o_cap = capture_a; o_run = running_a;
        o_fin = finish_a; o_end = bist_end_a; o_cnt = cnt_a;
      end
      chk("seed", 32'(o_seed), 32'(e_seed));
      chk("scan_en", 32'(o_scan), 32'(e_scan));
      chk("capture", 32'(o_cap), 32'(e_cap));
      chk("running", 32'(o_run), 32'(e_run));
      chk("finish", 32'(o_fin), 32'(e_fin));
      chk("bist_end", 32'(o_end), 32'(e_end));
      chk("pattern_cnt", 32'(o_cnt), 32'(e_cnt));
      if (o_scan === 1'b1) scan_cnt++;
      if (o_cap === 1'b1) cap_cnt++;
      if (o_fin === 1'b1) fin_cnt++;
      if (!use_b && t == toggle_at) start_a = 1'b0;
      if (!use_b && toggle_at >= 0 && t == toggle_at + 1) start_a = 1'b1;
    end
    chk("scan_en_total", 32'(scan_cnt), 32'((n + 1) * cl));
    chk("capture_total", 32'(cap_cnt), 32'(n));
    chk("finish_total", 32'(fin_cnt), 32'd1);
  endtask

  // Exactly one of seed/scan_en/capture while running; none otherwise.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("excl_a", 32'(seed_a) + 32'(scan_en_a) + 32'(capture_a), 32'(running_a === 1'b1));
      chk("run_end_a", 32'(running_a & bist_end_a), 0);
      chk("excl_b", 32'(seed_b) + 32'(scan_en_b) + 32'(capture_b), 32'(running_b === 1'b1));
      chk("run_end_b", 32'(running_b & bist_end_b), 0);
    end
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) step();
    chk_on = 1'b1;
    chk_a_idle("reset", 0, 0);
    rst = 1'b0;
    step();
    chk_a_idle("post_reset", 0, 0);

    // Scenario 1: full run with START held.
    start_a = 1'b1;
    run_check(1'b0, 4, 3, 2, -1);

    // Scenario 2: hold in DONE, release to IDLE, rerun.
    repeat (3) begin
      step();
      chk_a_idle("done_hold", 3, 1);
    end
    start_a = 1'b0;
    step();
    chk_a_idle("done_exit", 3, 0);
    start_a = 1'b1;
    run_check(1'b0, 4, 3, 2, -1);
    start_a = 1'b0;
    step();
    step();
    chk_a_idle("idle2", 3, 0);

    // Scenario 3: async reset during the second SHIFT phase (t=7..10).
    start_a = 1'b1;
    for (int t = 0; t <= 8; t++) step();
    chk("mid_scan", 32'(scan_en_a), 1);
    chk("mid_cnt", 32'(cnt_a), 1);
    #2 rst = 1'b1;
    #1;
    chk_a_idle("async_rst", 0, 0);
    step();
    rst = 1'b0;
    repeat (4) begin
      step();
      chk_a_idle("held_start", 0, 0);
    end
    start_a = 1'b0;
    step();
    chk_a_idle("rearm", 0, 0);

    // Scenario 4: START toggled during the first SHIFT phase is ignored.
    start_a = 1'b1;
    run_check(1'b0, 4, 3, 2, 3);
    start_a = 1'b0;
    step();
    chk_a_idle("after_toggle", 3, 0);

    // Scenario 5: minimum-length configuration.
    start_b = 1'b1;
    run_check(1'b1, 1, 1, 1, -1);
    start_b = 1'b0;
    step();
    chk("b_idle_end", 32'(bist_end_b), 0);
    chk("b_idle_cnt", 32'(cnt_b), 1);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
Name: bist_sequencer

Overview:
- Upstream BIST control stage for the scan-wrapped circuit under test.
- On a START request it sequences LFSR seeding, scan shift and capture phases for a fixed number of patterns, then a final unload.
- It drives the scan-enable/test-mode mux select, the LFSR seed strobe, and the end-of-test signals consumed by the MISR and comparator.

Parameters:
- CHAIN_LEN, 5, scan chain length; cycles per shift/unload phase (>=1)
- N_PATTERNS, 100, number of capture cycles per BIST run (>=1)
- SEED_CYCLES, 2, cycles SEED held high to load both LFSRs (>=1)
- CNT_W, 8, width of PATTERN_CNT; must hold N_PATTERNS

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  BIST request, level; a run begins on a 0->1 transition
- SCAN_EN  out  1  1 = scan shift / test-vector mux select; 0 = functional or capture
- SEED  out  1  LFSR seed-load strobe
- CAPTURE  out  1  one-cycle marker of each capture cycle
- RUNNING  out  1  high in every non-IDLE, non-DONE state
- FINISH  out  1  one-cycle pulse on entry to DONE; comparator evaluates the signature
- BIST_END  out  1  high for the whole DONE state; freezes the MISR
- PATTERN_CNT  out  CNT_W  captures completed in the current run

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; counters 0; START edge-detect register 0.
  - RST mid-run aborts immediately, with no FINISH pulse.
  - After release, a fresh START rising edge is required; a START still held high is not an edge.
- Outputs are registered Moore functions of state. FINISH is registered and fires on the DONE-entry edge.
- START edge detect: start_q <= START each cycle; edge = START & ~start_q. The edge is ignored in every state except IDLE.
- States and transitions:
  - IDLE: SCAN_EN=0. On edge -> SEED, phase counter cleared, PATTERN_CNT cleared.
  - SEED: SEED=1, SCAN_EN=0, for SEED_CYCLES cycles -> SHIFT.
  - SHIFT: SCAN_EN=1 for CHAIN_LEN cycles -> CAPTURE.
  - CAPTURE: SCAN_EN=0, CAPTURE=1 for 1 cycle. PATTERN_CNT increments on exit.
    - If the new count equals N_PATTERNS -> UNLOAD.
    - Otherwise -> SHIFT.
  - UNLOAD: SCAN_EN=1 for CHAIN_LEN cycles, flushing the last response into the MISR -> DONE.
  - DONE: BIST_END=1, RUNNING=0, FINISH=1 only in the first DONE cycle. Stays in DONE while START=1; START=0 -> IDLE, where BIST_END drops to 0 on the next edge.
- Phase counter: down-counter loaded on each state entry; it never wraps.
- PATTERN_CNT saturates at N_PATTERNS and holds its value through DONE. It is cleared only on a new run or on reset.
- Total run length from the first SEED cycle to the first DONE cycle: SEED_CYCLES + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN cycles.
- SCAN_EN-high cycle count per run: (N_PATTERNS+1)*CHAIN_LEN.
- START pulses during a run are ignored. A START glitch shorter than 1 cycle that is not sampled has no effect.
- Exactly one of SEED, SCAN_EN, CAPTURE is high in any RUNNING cycle.

Test Plan:
1. CHAIN_LEN=4, N_PATTERNS=3, SEED_CYCLES=2; RST then START 0->1 held:
   - SEED high 2 cycles, then SHIFT/CAPTURE pattern 4/1 repeated 3 times, then SCAN_EN high 4.
   - FINISH pulses exactly once, 21 cycles after SEED first rises.
   - SCAN_EN high 16 cycles total; PATTERN_CNT=3 at DONE.
2. Same params, START held high after DONE:
   - BIST_END stays 1, FINISH does not re-pulse.
   - START=0 -> IDLE next cycle with BIST_END=0.
   - A new START edge repeats scenario 1 exactly.
3. Assert RST in the 2nd SHIFT phase:
   - All outputs 0 asynchronously, no FINISH, PATTERN_CNT=0.
   - After release with START still 1, the block remains IDLE.
4. Toggle START 1->0->1 during a SHIFT phase:
   - Sequence timing unchanged; the run completes with a single FINISH at the scenario-1 cycle.
5. CHAIN_LEN=1, N_PATTERNS=1, SEED_CYCLES=1:
   - Sequence is SEED(1), SHIFT(1), CAPTURE(1), UNLOAD(1), DONE.
   - FINISH 4 cycles after SEED rises.
6. Checker over all runs:
   - SEED, SCAN_EN and CAPTURE are mutually exclusive.
   - RUNNING and BIST_END are never both 1.
   - CAPTURE count equals N_PATTERNS per completed run.
